bp_fe_bht_gshare: RTL and testbench
===================================

# bp_fe_bht_gshare

Parametrised branch history table for the front end: a table of saturating counters indexed by PC bits, optionally XOR-hashed with a speculative global history register (gshare). It gives a registered taken/not-taken prediction one cycle after a lookup, and returns the history snapshot used so the back-end update can train the same entry. Mispredict repair restores the history. After reset, a sweep state machine initialises the table.

## Interface
- bht_idx_width_p, 9: table index width; table holds 2**bht_idx_width_p counters
- ctr_width_p, 2: saturating counter width (>=2)
- ghist_width_p, 8: global history length (1..bht_idx_width_p)
- hash_mode_p, 1: 0 = bimodal (index = PC index only), 1 = gshare (index XOR history)

- clk_i  input  1  clock
- reset_i  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- init_done_o  output  1  table initialised; lookups and updates are accepted
- r_v_i  input  1  lookup request
- r_idx_i  input  bht_idx_width_p  lookup PC index
- predict_v_o  output  1  prediction valid (registered)
- predict_taken_o  output  1  predicted direction
- predict_ghist_o  output  ghist_width_p  history used for this lookup
- w_v_i  input  1  update (resolved branch)
- w_idx_i  input  bht_idx_width_p  PC index of the resolved branch
- w_ghist_i  input  ghist_width_p  predict_ghist_o captured at prediction
- w_taken_i  input  1  actual outcome
- w_mispredict_i  input  1  predicted direction was wrong; repair history

## Operation
- Hash: h(idx, g) = idx ^ zero-extended g, with history in the low bits, when hash_mode_p=1; h = idx when hash_mode_p=0.
- Counter init value: 2**(ctr_width_p-1)-1, which is weakly not-taken (01 for 2 bits). Prediction is the counter MSB.
- FSM states:
  - INIT: an index counter starts at 0 and writes the init value to one entry per cycle. After entry els-1 is written, the FSM moves to READY. init_done_o=0 while in INIT.
  - READY: init_done_o=1.
- Lookup (READY and r_v_i):
  - Read entry h(r_idx_i, ghist) combinationally.
  - Register the MSB to predict_taken_o and the current ghist to predict_ghist_o.
  - ghist <= {ghist[ghist_width_p-2:0], predicted bit}.
- Update (READY and w_v_i):
  - Entry h(w_idx_i, w_ghist_i): increment on w_taken_i, saturating at 2**ctr_width_p-1; otherwise decrement, saturating at 0.
  - If w_mispredict_i: ghist <= {w_ghist_i[ghist_width_p-2:0], w_taken_i}.
- Simultaneous lookup and update:
  - Write-first bypass: if the hashed indices match, the prediction uses the post-update counter MSB.
  - History: mispredict repair has priority over the speculative shift. The lookup still returns a prediction formed from the pre-repair history.
- r_v_i and w_v_i are ignored in INIT. predict_v_o stays 0 in INIT.
- reset_i in any state, including mid-INIT, returns the FSM to INIT at index 0 and clears ghist. The sweep restarts from index 0.

## Timing
- Reset values: init_done_o=0, predict_v_o=0, predict_taken_o=0, predict_ghist_o=0, ghist=0.
- init_done_o rises exactly 2**bht_idx_width_p cycles after the first cycle with reset_i low.
- Lookup latency is 1: r_v_i sampled at edge N produces predict_v_o=1 in cycle N+1. predict_v_o is 0 in cycles without an accepted lookup.
- A lookup is accepted every cycle, with no stall. Back-to-back lookups see the history that already includes the previous prediction.
- Update latency is 1: a counter written at edge N is visible to a lookup in cycle N+1, or to a lookup in cycle N through the bypass.
- History repair takes effect at the same edge as the update.

## Test plan
- Reset, then count cycles: init_done_o=0 for exactly 512 cycles (idx 9), then 1. A lookup of any index gives predict_taken_o=0, predict_ghist_o=0.
- Bimodal mode (hash_mode_p=0), idx 5:
  - Updates taken, then taken: counter 01->10->11. The next lookup predicts taken.
  - Three further taken updates keep the counter at 11.
  - Updates not-taken, then not-taken: lookup predicts 0 (01), then 00 saturates.
- gshare speculative history:
  - Three back-to-back lookups whose predictions are 0,0,0 return predict_ghist_o = 0x00, 0x00, 0x00.
  - After training idx 3 with history 0 to taken, lookups give ghist 0x00 then 0x01.
- Mispredict repair: w_ghist_i=0x5A, w_taken_i=1, w_mispredict_i=1 together with r_v_i. The next-cycle lookup reports predict_ghist_o=0xB5.
- Bypass: with entry E=01, a same-cycle update taken to E and a lookup hashing to E give predict_taken_o=1 in the next cycle.
- Reset during INIT at cycle 100 restarts the sweep. A counter trained before the reset reads back as the init value after init_done_o rises.

Source files
------------

// File: rtl/bp_fe_bht_gshare.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_bht_gshare
// Purpose  : Front-end branch history table of saturating counters. The table
//            index is the PC index, optionally XOR-hashed with a speculative
//            global history register (gshare). A prediction is registered one
//            cycle after a lookup, together with the history snapshot that
//            formed it, so the back end can train the same entry later.
//            After reset a sweep FSM writes the init value into every entry.
// Ports    : clk_i, reset_i            clock, synchronous active-high reset
//            init_done_o               table swept, lookups/updates accepted
//            r_v_i, r_idx_i            lookup request and PC index
//            predict_v_o/taken_o/ghist_o  registered prediction + history used
//            w_v_i, w_idx_i, w_ghist_i, w_taken_i, w_mispredict_i
//                                      resolved-branch update and repair
// Revision : 1.0  initial release
// ============================================================================
module bp_fe_bht_gshare #(
    parameter int bht_idx_width_p = 9,
    parameter int ctr_width_p     = 2,
    parameter int ghist_width_p   = 8,
    parameter int hash_mode_p     = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       init_done_o,

    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] r_idx_i,
    output logic                       predict_v_o,
    output logic                       predict_taken_o,
    output logic [ghist_width_p-1:0]   predict_ghist_o,

    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] w_idx_i,
    input  logic [ghist_width_p-1:0]   w_ghist_i,
    input  logic                       w_taken_i,
    input  logic                       w_mispredict_i
);

    localparam int c_ELS = 1 << bht_idx_width_p;

    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [ctr_width_p-1:0] c_CTR_INIT = {1'b0, {(ctr_width_p-1){1'b1}}};
    localparam logic [ctr_width_p-1:0] c_CTR_MAX  = {ctr_width_p{1'b1}};
    localparam logic [ctr_width_p-1:0] c_CTR_MIN  = '0;
    localparam logic [ctr_width_p-1:0] c_CTR_ONE  = ctr_width_p'(1);

    localparam logic [bht_idx_width_p-1:0] c_IDX_LAST = {bht_idx_width_p{1'b1}};
    localparam logic [bht_idx_width_p-1:0] c_IDX_ONE  = bht_idx_width_p'(1);

    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    logic [ctr_width_p-1:0]     r_mem [c_ELS];
    logic [0:0]                 r_state;
    logic [bht_idx_width_p-1:0] r_init_idx;
    logic [ghist_width_p-1:0]   r_ghist;
    logic                       r_predict_v;
    logic                       r_predict_taken;
    logic [ghist_width_p-1:0]   r_predict_ghist;

    logic                       w_ready;
    logic                       w_lookup;
    logic                       w_update;
    logic [bht_idx_width_p-1:0] w_r_hash;
    logic [bht_idx_width_p-1:0] w_w_hash;
    logic [ctr_width_p-1:0]     w_ctr_old;
    logic [ctr_width_p-1:0]     w_ctr_new;
    logic                       w_pred_bit;
    logic [ghist_width_p-1:0]   w_ghist_shift;
    logic [ghist_width_p-1:0]   w_ghist_repair;

    assign w_ready  = (r_state == c_ST_READY);
    assign w_lookup = w_ready & r_v_i;
    assign w_update = w_ready & w_v_i;

    // ------------------------------------------------------------------
    // Index hash. History is zero-extended into the low index bits.
    // ------------------------------------------------------------------
    generate
        if (hash_mode_p != 0) begin : g_hash_gshare
            assign w_r_hash = r_idx_i ^ bht_idx_width_p'(r_ghist);
            assign w_w_hash = w_idx_i ^ bht_idx_width_p'(w_ghist_i);
        end else begin : g_hash_bimodal
            assign w_r_hash = r_idx_i;
            assign w_w_hash = w_idx_i;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Saturating counter update for the resolved branch.
    // ------------------------------------------------------------------
    assign w_ctr_old = r_mem[w_w_hash];

    always_comb begin
        w_ctr_new = w_ctr_old;
        if (w_taken_i) begin
            if (w_ctr_old != c_CTR_MAX) begin
                w_ctr_new = w_ctr_old + c_CTR_ONE;
            end
        end else begin
            if (w_ctr_old != c_CTR_MIN) begin
                w_ctr_new = w_ctr_old - c_CTR_ONE;
            end
        end
    end

    // Write-first: a same-cycle update to the looked-up entry is forwarded
    // so the prediction never sees a stale counter.
    always_comb begin
        w_pred_bit = r_mem[w_r_hash][ctr_width_p-1];
        if (w_update && (w_w_hash == w_r_hash)) begin
            w_pred_bit = w_ctr_new[ctr_width_p-1];
        end
    end

    // ------------------------------------------------------------------
    // Next-history candidates: speculative shift and mispredict repair.
    // ------------------------------------------------------------------
    generate
        if (ghist_width_p > 1) begin : g_hist_wide
            assign w_ghist_shift  = {r_ghist[ghist_width_p-2:0], w_pred_bit};
            assign w_ghist_repair = {w_ghist_i[ghist_width_p-2:0], w_taken_i};
        end else begin : g_hist_one
            assign w_ghist_shift  = w_pred_bit;
            assign w_ghist_repair = w_taken_i;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control: sweep FSM, history register, prediction registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state         <= c_ST_INIT;
            r_init_idx      <= '0;
            r_ghist         <= '0;
            r_predict_v     <= 1'b0;
            r_predict_taken <= 1'b0;
            r_predict_ghist <= '0;
        end else begin
            r_predict_v <= w_lookup;
            case (r_state)
                c_ST_INIT: begin
                    r_init_idx <= r_init_idx + c_IDX_ONE;
                    if (r_init_idx == c_IDX_LAST) begin
                        r_state <= c_ST_READY;
                    end
                end
                default: begin
                    if (w_lookup) begin
                        r_predict_taken <= w_pred_bit;
                        r_predict_ghist <= r_ghist;
                    end
                    // Repair wins over the speculative shift; the lookup
                    // above still reports the pre-repair history.
                    if (w_update && w_mispredict_i) begin
                        r_ghist <= w_ghist_repair;
                    end else if (w_lookup) begin
                        r_ghist <= w_ghist_shift;
                    end
                end
            endcase
        end
    end

    // Counter storage: no reset, the sweep initialises it.
    always_ff @(posedge clk_i) begin
        if (r_state == c_ST_INIT) begin
            r_mem[r_init_idx] <= c_CTR_INIT;
        end else if (w_update) begin
            r_mem[w_w_hash] <= w_ctr_new;
        end
    end

    assign init_done_o     = w_ready;
    assign predict_v_o     = r_predict_v;
    assign predict_taken_o = r_predict_taken;
    assign predict_ghist_o = r_predict_ghist;

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_bht_gshare.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_fe_bht_gshare
// Purpose  : Directed self-checking bench. One gshare instance (default
//            parameters) and one bimodal instance share clock and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_fe_bht_gshare;

    logic       clk = 1'b0;
    logic       reset_i;

    // gshare instance stimulus/observation
    logic       r_v;
    logic [8:0] r_idx;
    logic       w_v;
    logic [8:0] w_idx;
    logic [7:0] w_ghist;
    logic       w_taken;
    logic       w_mis;
    logic       init_done;
    logic       pv;
    logic       pt;
    logic [7:0] pg;

    // bimodal instance stimulus/observation
    logic       bm_r_v;
    logic [8:0] bm_r_idx;
    logic       bm_w_v;
    logic [8:0] bm_w_idx;
    logic       bm_w_taken;
    logic       bm_init_done;
    logic       bm_pv;
    logic       bm_pt;
    logic [7:0] bm_pg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bp_fe_bht_gshare #(
        .bht_idx_width_p (9),
        .ctr_width_p     (2),
        .ghist_width_p   (8),
        .hash_mode_p     (1)
    ) u_dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .init_done_o     (init_done),
        .r_v_i           (r_v),
        .r_idx_i         (r_idx),
        .predict_v_o     (pv),
        .predict_taken_o (pt),
        .predict_ghist_o (pg),
        .w_v_i           (w_v),
        .w_idx_i         (w_idx),
        .w_ghist_i       (w_ghist),
        .w_taken_i       (w_taken),
        .w_mispredict_i  (w_mis)
    );

    bp_fe_bht_gshare #(
        .bht_idx_width_p (9),
        .ctr_width_p     (2),
        .ghist_width_p   (8),
        .hash_mode_p     (0)
    ) u_dut_bm (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .init_done_o     (bm_init_done),
        .r_v_i           (bm_r_v),
        .r_idx_i         (bm_r_idx),
        .predict_v_o     (bm_pv),
        .predict_taken_o (bm_pt),
        .predict_ghist_o (bm_pg),
        .w_v_i           (bm_w_v),
        .w_idx_i         (bm_w_idx),
        .w_ghist_i       (8'hFF),
        .w_taken_i       (bm_w_taken),
        .w_mispredict_i  (1'b0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // gshare: single-cycle lookup, then check the registered result
    task automatic g_lookup(input string tag, input logic [8:0] idx,
                            input logic exp_t, input logic [7:0] exp_g);
        r_v   = 1'b1;
        r_idx = idx;
        tick();
        r_v   = 1'b0;
        check({tag, "_v"}, 32'(pv), 32'd1);
        check({tag, "_taken"}, 32'(pt), 32'(exp_t));
        check({tag, "_ghist"}, 32'(pg), 32'(exp_g));
    endtask

    task automatic g_update(input logic [8:0] idx, input logic [7:0] gh,
                            input logic taken, input logic mis);
        w_v     = 1'b1;
        w_idx   = idx;
        w_ghist = gh;
        w_taken = taken;
        w_mis   = mis;
        tick();
        w_v     = 1'b0;
        w_mis   = 1'b0;
    endtask

    task automatic b_update(input logic taken);
        bm_w_v     = 1'b1;
        bm_w_idx   = 9'd5;
        bm_w_taken = taken;
        tick();
        bm_w_v     = 1'b0;
    endtask

    task automatic b_lookup(input string tag, input logic exp_t);
        bm_r_v   = 1'b1;
        bm_r_idx = 9'd5;
        tick();
        bm_r_v   = 1'b0;
        check({tag, "_v"}, 32'(bm_pv), 32'd1);
        check({tag, "_taken"}, 32'(bm_pt), 32'(exp_t));
    endtask

    initial begin
        int  cnt;
        logic saw_pv;

        reset_i = 1'b1;
        r_v = 1'b0; r_idx = '0; w_v = 1'b0; w_idx = '0; w_ghist = '0;
        w_taken = 1'b0; w_mis = 1'b0;
        bm_r_v = 1'b0; bm_r_idx = '0; bm_w_v = 1'b0; bm_w_idx = '0; bm_w_taken = 1'b0;
        tick(); tick(); tick();

        // Reset values
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_pv", 32'(pv), 32'd0);
        check("rst_pt", 32'(pt), 32'd0);
        check("rst_pg", 32'(pg), 32'd0);

        // Sweep length
        reset_i = 1'b0;
        cnt = 0;
        while (!init_done && cnt < 2000) begin
            tick();
            cnt++;
        end
        check("init_cycles", 32'(cnt), 32'd512);
        check("bm_init_done", 32'(bm_init_done), 32'd1);

        // Fresh table: any index predicts not-taken with empty history
        g_lookup("fresh", 9'h1A3, 1'b0, 8'h00);
        tick();
        check("idle_pv", 32'(pv), 32'd0);

        // Bimodal counter at idx 5: 01 -> 10 -> 11
        b_update(1'b1);
        b_update(1'b1);
        b_lookup("bm_t2", 1'b1);
        b_update(1'b1);
        b_update(1'b1);
        b_update(1'b1);
        b_update(1'b0);                 // 11 -> 10 only if saturated high
        b_lookup("bm_sat_hi", 1'b1);
        b_update(1'b0);                 // -> 01
        b_lookup("bm_nt2", 1'b0);
        b_update(1'b0);                 // -> 00
        b_update(1'b0);                 // stays 00
        b_update(1'b1);                 // -> 01
        b_lookup("bm_sat_lo", 1'b0);
        b_update(1'b1);                 // -> 10
        b_lookup("bm_recover", 1'b1);

        // gshare: back-to-back not-taken predictions keep history at 0
        r_v = 1'b1;
        r_idx = 9'h010; tick();
        check("b2b0_taken", 32'(pt), 32'd0);
        check("b2b0_ghist", 32'(pg), 32'h00);
        r_idx = 9'h020; tick();
        check("b2b1_ghist", 32'(pg), 32'h00);
        r_idx = 9'h030; tick();
        check("b2b2_ghist", 32'(pg), 32'h00);
        r_v = 1'b0;

        // Train idx 3 under history 0 to strongly taken
        g_update(9'd3, 8'h00, 1'b1, 1'b0);
        g_update(9'd3, 8'h00, 1'b1, 1'b0);
        r_v = 1'b1;
        r_idx = 9'd3; tick();           // hash 3: taken, ghist 0 -> 1
        check("trn0_taken", 32'(pt), 32'd1);
        check("trn0_ghist", 32'(pg), 32'h00);
        r_idx = 9'd3; tick();           // hash 3^1=2: init, ghist 1 -> 2
        check("trn1_taken", 32'(pt), 32'd0);
        check("trn1_ghist", 32'(pg), 32'h01);
        r_v = 1'b0;

        // Mispredict repair alongside a lookup (history is 0x02 here)
        r_v = 1'b1; r_idx = 9'h050;
        w_v = 1'b1; w_idx = 9'h040; w_ghist = 8'h5A; w_taken = 1'b1; w_mis = 1'b1;
        tick();
        w_v = 1'b0; w_mis = 1'b0;
        check("rep_pre_ghist", 32'(pg), 32'h02);
        check("rep_pre_taken", 32'(pt), 32'd0);
        r_idx = 9'h000; tick();         // history now 0xB5 -> 0x6A
        r_v = 1'b0;
        check("rep_ghist", 32'(pg), 32'hB5);

        // Bypass: lookup 0x100 ^ 0x6A = 0x16A, same-cycle taken update to 0x16A
        r_v = 1'b1; r_idx = 9'h100;
        w_v = 1'b1; w_idx = 9'h16A; w_ghist = 8'h00; w_taken = 1'b1; w_mis = 1'b0;
        tick();
        r_v = 1'b0; w_v = 1'b0;
        check("byp_taken", 32'(pt), 32'd1);
        check("byp_ghist", 32'(pg), 32'h6A);
        // History now 0xD5; 0x1BF ^ 0xD5 = 0x16A, counter committed as 10
        g_lookup("byp_commit", 9'h1BF, 1'b1, 8'hD5);

        // Reset in the middle of the sweep
        reset_i = 1'b1; tick();
        reset_i = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("mid_init_done", 32'(init_done), 32'd0);
        reset_i = 1'b1; tick();
        check("mid_rst_done", 32'(init_done), 32'd0);
        check("mid_rst_pg", 32'(pg), 32'h00);
        reset_i = 1'b0;
        // Requests during the sweep must be ignored
        r_v = 1'b1; r_idx = 9'd3;
        w_v = 1'b1; w_idx = 9'd3; w_ghist = 8'h00; w_taken = 1'b1;
        saw_pv = 1'b0;
        cnt = 0;
        while (!init_done && cnt < 2000) begin
            tick();
            cnt++;
            if (pv) saw_pv = 1'b1;
        end
        r_v = 1'b0; w_v = 1'b0;
        check("reinit_cycles", 32'(cnt), 32'd512);
        check("init_no_pv", 32'(saw_pv), 32'd0);
        g_lookup("reinit_idx3", 9'd3, 1'b0, 8'h00);
        b_lookup("bm_reinit", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
